// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl
//   Top-level game sequencer for the Dino runner. Runs the
//   IDLE -> RUNNING -> OVER_HOLD -> OVER_READY lifecycle. It generates the
//   start/over/clear pulses for the BCD score counter, enforces a restart
//   lock-out after a crash, tracks the session high score and derives a
//   speed level from the live score.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   i_game_tick     60 Hz end-of-frame strobe (one clk wide)
//   i_jump_btn      debounced jump button level
//   i_collision     collision flag (level or pulse)
//   i_score[15:0]   live 4-digit BCD score, digit 3 in [15:12]
//   o_game_start    1-cycle pulse: score counter begins counting
//   o_game_over     1-cycle pulse: score counter stops
//   o_score_clr     1-cycle pulse clearing the score, coincident with start
//   o_running       high while RUNNING
//   o_state[1:0]    IDLE=00 RUNNING=01 OVER_HOLD=10 OVER_READY=11
//   o_high_score    best BCD score since power-up
//   o_new_record    set by a record-setting game over, cleared on next start
//   o_level[2:0]    speed level from score, saturating at MAX_LEVEL
module game_flow_ctrl #(
    parameter int OVER_HOLD_TICKS = 30,
    parameter int MAX_LEVEL       = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_game_tick,
    input  logic        i_jump_btn,
    input  logic        i_collision,
    input  logic [15:0] i_score,
    output logic        o_game_start,
    output logic        o_game_over,
    output logic        o_score_clr,
    output logic        o_running,
    output logic [1:0]  o_state,
    output logic [15:0] o_high_score,
    output logic        o_new_record,
    output logic [2:0]  o_level
);

    localparam int CW = (OVER_HOLD_TICKS > 1) ? $clog2(OVER_HOLD_TICKS + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE       = 2'b00,
        S_RUNNING    = 2'b01,
        S_OVER_HOLD  = 2'b10,
        S_OVER_READY = 2'b11
    } state_t;

    state_t          r_state;
    logic            r_btn_prev;
    logic [CW-1:0]   r_hold_cnt;
    logic            r_start;
    logic            r_over;
    logic            r_clr;
    logic            r_running;
    logic            r_over_d;
    logic [15:0]     r_high_score;
    logic            r_new_record;
    logic [2:0]      r_level;

    logic            w_press;
    logic [3:0]      w_thou;
    logic [3:0]      w_hund;
    logic [2:0]      w_level;

    assign w_press = i_jump_btn & ~r_btn_prev;
    assign w_thou  = i_score[15:12];
    assign w_hund  = i_score[11:8];
    // Hundreds digit below MAX_LEVEL always fits in 3 bits.
    assign w_level = ((w_thou != 4'd0) || (w_hund >= 4'(MAX_LEVEL))) ?
                     3'(MAX_LEVEL) : w_hund[2:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            // Starts at 1 so a button held through reset is not a press.
            r_btn_prev   <= 1'b1;
            r_hold_cnt   <= '0;
            r_start      <= 1'b0;
            r_over       <= 1'b0;
            r_clr        <= 1'b0;
            r_running    <= 1'b0;
            r_over_d     <= 1'b0;
            r_high_score <= 16'h0000;
            r_new_record <= 1'b0;
            r_level      <= 3'd0;
        end else begin
            r_btn_prev <= i_jump_btn;
            r_start    <= 1'b0;
            r_over     <= 1'b0;
            r_clr      <= 1'b0;
            r_over_d   <= r_over;
            r_level    <= w_level;

            // The counter may take one last tick during the game_over cycle,
            // so the record compare waits one more cycle for the final score.
            // BCD words compare correctly as plain unsigned integers.
            if (r_over_d && (i_score > r_high_score)) begin
                r_high_score <= i_score;
                r_new_record <= 1'b1;
            end

            case (r_state)
                S_IDLE, S_OVER_READY: begin
                    if (w_press) begin
                        r_state      <= S_RUNNING;
                        r_running    <= 1'b1;
                        r_start      <= 1'b1;
                        r_clr        <= 1'b1;
                        r_new_record <= 1'b0;
                        r_level      <= 3'd0;
                    end
                end
                S_RUNNING: begin
                    // Collision outranks any press in the same cycle.
                    if (i_collision) begin
                        r_state    <= S_OVER_HOLD;
                        r_running  <= 1'b0;
                        r_over     <= 1'b1;
                        r_hold_cnt <= CW'(OVER_HOLD_TICKS);
                    end
                end
                S_OVER_HOLD: begin
                    if (OVER_HOLD_TICKS == 0) begin
                        r_state <= S_OVER_READY;
                    end else if (i_game_tick) begin
                        r_hold_cnt <= r_hold_cnt - CW'(1);
                        if (r_hold_cnt <= CW'(1))
                            r_state <= S_OVER_READY;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign o_game_start = r_start;
    assign o_game_over  = r_over;
    assign o_score_clr  = r_clr;
    assign o_running    = r_running;
    assign o_state      = r_state;
    assign o_high_score = r_high_score;
    assign o_new_record = r_new_record;
    assign o_level      = r_level;

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Top-level game sequencer for the Dino runner.
- Owns the IDLE/RUNNING/GAME-OVER lifecycle and generates the start, over and clear pulses that drive the BCD score counter.
- Holds a restart lock-out after a crash.
- Tracks the session high score and derives a speed level from the live BCD score for the obstacle/physics logic.

Parameters:
OVER_HOLD_TICKS, 30, game_tick frames after a crash during which restart presses are ignored (0 = no lock-out)
MAX_LEVEL, 7, saturation value of the level output (must fit 3 bits)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
game_tick  input  1  60 Hz end-of-frame pulse, one clk wide
jump_btn  input  1  synchronized, debounced jump button level
collision  input  1  collision flag from the collision detector (level or pulse)
score  input  16  live 4-digit BCD score from the score counter, digit 3 in [15:12]
game_start  output  1  one-cycle pulse to the score counter: begin counting
game_over  output  1  one-cycle pulse to the score counter: stop counting
score_clr  output  1  one-cycle pulse clearing the score counter, coincident with game_start
running  output  1  high while the state is RUNNING; gates sprite and physics motion
state  output  2  IDLE=00, RUNNING=01, OVER_HOLD=10, OVER_READY=11
high_score  output  16  best BCD score this power-up
new_record  output  1  high from a record-setting game over until the next game_start
level  output  3  speed level derived from score

Behaviour:
- Reset (asynchronous, any time including mid-game):
  - state=IDLE, all pulses 0, running=0.
  - high_score=0, new_record=0, level=0, hold counter=0.
  - Button-history register = 1, so a button held through reset must be released before it counts as a press.
- Press = jump_btn high in the current cycle while the history register (previous-cycle value) is 0. History updates every cycle in every state.
- All outputs are registered. Pulses are high exactly one cycle, in the cycle after the triggering condition is sampled.
- IDLE:
  - Press -> state RUNNING; game_start=1 and score_clr=1 next cycle.
  - collision ignored.
- RUNNING:
  - collision=1 in any cycle -> state OVER_HOLD; game_over=1 next cycle; hold counter loaded with OVER_HOLD_TICKS.
  - Presses are ignored.
  - collision and press in the same cycle -> collision wins.
- OVER_HOLD:
  - Each game_tick decrements the hold counter.
  - A game_tick seen with counter==1 -> OVER_READY.
  - If OVER_HOLD_TICKS=0, move to OVER_READY on the next clk regardless of game_tick.
  - Presses and collision ignored.
- OVER_READY:
  - Press -> RUNNING, with game_start + score_clr exactly as from IDLE.
  - A button held since OVER_HOLD does not restart; it must be released and pressed again.
- running = (state==RUNNING), registered with state.
- High score:
  - The score counter may still take one final tick during the game_over cycle.
  - The compare therefore uses score in the cycle after game_over (delayed-flag cycle). The update lands on the following edge, i.e. high_score is valid 2 cycles after game_over.
  - 16-bit unsigned compare of the BCD words; valid because digit order equals magnitude order.
  - If score > high_score: high_score <= score and new_record <= 1. Equal score is not a record.
  - new_record clears in the cycle game_start asserts.
- Level:
  - Registered every cycle from score.
  - level = MAX_LEVEL if thousands digit != 0 or hundreds digit >= MAX_LEVEL; else level = hundreds digit.
  - Forced to 0 in the cycle score_clr asserts.
- The score counter wraps at 9999 -> 0000. level follows the wrap; high_score keeps its value.
- Unused state encodings recover to IDLE on the next clk.

Test Plan:
- Reset with jump_btn held high, then keep it high for 10 cycles -> no game_start, state stays 00. Release, then press -> game_start and score_clr high for one cycle, one cycle after the press; state 01, running=1.
- RUNNING with score=0x0123, assert collision one cycle -> game_over pulse next cycle, state 10; two cycles after game_over, high_score=0x0123 and new_record=1.
- OVER_HOLD_TICKS=30: press at ticks 5 and 29 -> ignored. After the 30th game_tick state becomes 11; a press then gives game_start and clears new_record.
- Second game ending at score=0x0123 -> high_score unchanged, new_record=0. Third game ending at 0x0500 -> high_score=0x0500.
- Score ramp: score 0x0299 -> level 2; 0x0700 -> 7; 0x1000 -> 7; score_clr -> level 0.
- collision and press asserted in the same RUNNING cycle -> game_over only. Assert rst mid-OVER_HOLD -> all outputs at reset values immediately, state 00.
